aq_ejpeg_rgb2ycbcr: RTL
=======================

AQ_EJPEG_RGB2YCBCR -- requirements
Module: aq_ejpeg_rgb2ycbcr

Interface
REQ-001 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- ProcessInit  in  1  per-image clear
- JpegComp  in  3  3 = YCbCr, 1 = grayscale
- InEnable  in  1  pixel valid
- InReady  out  1  pixel accepted when InEnable&&InReady
- InR, InG, InB  in  8 each  RGB pixel, unsigned
- OutReady  in  1  sink ready
- OutEnable  out  1  sample valid
- OutColor  out  2  0=Y, 1=Cb, 2=Cr
- OutIndex  out  6  position in block, 0..63
- OutData  out  9  level-shifted sample, two's complement
- OutLast  out  1  final sample of the block set
REQ-002 SHALL expect input in block order: 64 pixels per 8x8 block, raster order within the block.

Function
REQ-003 SHALL compute with 2-cycle pipeline (accept at t, RAM write at t+2):
- Y = (77R+150G+29B+128)>>8
- Cb = ((-43R-85G+128B+128)>>>8)+128
- Cr = ((128R-107G-21B+128)>>>8)+128
REQ-004 SHALL clamp each result to 0..255, then subtract 128 to give a 9-bit signed value in -128..127.
REQ-005 SHALL hold two banks, each Y/Cb/Cr x 64 samples; the writer fills one bank while the reader drains the other.
REQ-006 SHALL count accepted pixels 0..63 (wrap to 0). The bank is marked full one cycle after the 64th write, and the write bank toggles.
REQ-007 SHALL drive InReady=0 when the next write bank is still full, or when the pipeline holds the 64th pixel and the other bank is full. No pixel is ever dropped.
REQ-008 Reader FSM states: IDLE -> READ (1-cycle RAM fetch) -> SEND -> READ/IDLE.
- IDLE: leaves when the read bank is full.
- SEND: OutEnable=1; OutColor, OutIndex, OutData stable until OutEnable&&OutReady.
REQ-009 SHALL emit Y 0..63, then Cb 0..63, then Cr 0..63 (Y only when grayscale). OutLast=1 only with the final sample.
REQ-010 On OutLast accepted, SHALL clear the bank-full flag and toggle the read bank.
REQ-011 When the read bank becomes free and the write bank becomes full in the same cycle, both flags SHALL update correctly; the reader returns to READ without passing through IDLE.
REQ-012 Holding OutReady=0 SHALL stall the output with no change in values. Input continues until both banks are full.
REQ-013 ProcessInit SHALL, one cycle later:
- clear banks, flags, counters and pipeline valids;
- force reader to IDLE, OutEnable=0, InReady=1.
In-flight data is discarded. ProcessInit has priority over a simultaneous accept.

Reset
REQ-014 With rst=0 at a clk edge, SHALL reset all state as in REQ-013.
REQ-015 Output values in reset: InReady=0, OutEnable=0, OutColor=0, OutIndex=0, OutData=0, OutLast=0.
REQ-016 SHALL drive InReady=1 on the first cycle after reset is released.
REQ-017 A reset mid-block SHALL discard the partial block.

Configuration
REQ-018 Macro AQ_EJPEG_GRAY_EN:
- Defined: JpegComp==1 selects grayscale; only Y is written and emitted, and OutLast comes at Y index 63.
- Undefined: JpegComp is ignored, 3 components are always produced, and the Cb/Cr paths are always present.

Verification
REQ-019 64 pixels (255,255,255) -> 64 Y samples of 127, then 64 Cb of 0, then 64 Cr of 0. OutLast only at Cr index 63.
REQ-020 64 pixels (255,0,0) -> Y=-51, Cb=-43, Cr=127 (clamped from 256).
REQ-021 OutReady=0 while 3 blocks are streamed -> InReady falls after the 128th pixel. Raising OutReady drains blocks 1 and 2 intact. The 3rd block is then accepted.
REQ-022 ProcessInit asserted at pixel 30 of a block, then one full block of (0,0,0) -> only that block is emitted: Y=-128, Cb=0, Cr=0.
REQ-023 With AQ_EJPEG_GRAY_EN defined and JpegComp=1, pixels (0,0,255) -> 64 samples of Y=-99 only, with OutLast at index 63.
REQ-024 Random OutReady toggling over 10 blocks -> output sequence matches a reference model and OutData never changes while stalled.

Source files
------------

// File: rtl/aq_ejpeg_rgb2ycbcr.sv
// RGB to level-shifted YCbCr converter with a double-banked 8x8 block buffer.
// Optional grayscale mode (Y only) is enabled by defining AQ_EJPEG_GRAY_EN.
module aq_ejpeg_rgb2ycbcr (
    input  logic       clk,
    input  logic       rst,
    input  logic       ProcessInit,
    input  logic [2:0] JpegComp,
    input  logic       InEnable,
    output logic       InReady,
    input  logic [7:0] InR,
    input  logic [7:0] InG,
    input  logic [7:0] InB,
    input  logic       OutReady,
    output logic       OutEnable,
    output logic [1:0] OutColor,
    output logic [5:0] OutIndex,
    output logic [8:0] OutData,
    output logic       OutLast
);

    // state | meaning
    // IDLE  | waiting for the read bank to fill
    // READ  | fetching one sample from the block RAM
    // SEND  | sample presented, waiting for OutReady
    typedef enum logic [1:0] {IDLE, READ, SEND} state_t;

    state_t state, state_nxt;

    logic clr;
    logic gray;
    logic accept;

    logic       in_bank;
    logic [5:0] in_cnt;
    logic [1:0] full, full_nxt;

    logic signed [17:0] r_s, g_s, b_s;
    logic signed [17:0] sum_y, sum_cb, sum_cr;

    logic               v1, b1;
    logic [5:0]         i1;
    logic signed [17:0] sy1, scb1, scr1;

    logic       v2, b2;
    logic [5:0] i2;
    logic [8:0] y2, cb2, cr2;
    logic       set_full;

    logic [8:0] mem_y  [0:127];
    logic [8:0] mem_cb [0:127];
    logic [8:0] mem_cr [0:127];

    logic       rd_bank;
    logic [1:0] rd_color;
    logic [5:0] rd_idx;
    logic [6:0] rd_addr;
    logic       rd_last;
    logic       other_full;
    logic       load, done, free;

    assign clr = !rst || ProcessInit;

`ifdef AQ_EJPEG_GRAY_EN
    assign gray = (JpegComp == 3'd1);
`else
    logic unused_jpeg_comp;
    assign unused_jpeg_comp = ^JpegComp;
    assign gray = 1'b0;
`endif

    // The accept side moves to the next bank as soon as the 64th pixel is taken,
    // so the only thing that can block input is that bank still being drained.
    assign InReady = rst && !full[in_bank];
    assign accept  = InEnable && InReady;

    assign r_s = $signed({10'd0, InR});
    assign g_s = $signed({10'd0, InG});
    assign b_s = $signed({10'd0, InB});

    assign sum_y  = 18'sd77 * r_s + 18'sd150 * g_s + 18'sd29 * b_s + 18'sd128;
    assign sum_cb = 18'sd128 * b_s - 18'sd43 * r_s - 18'sd85 * g_s + 18'sd128;
    assign sum_cr = 18'sd128 * r_s - 18'sd107 * g_s - 18'sd21 * b_s + 18'sd128;

    function automatic logic [8:0] level(input logic signed [17:0] s, input logic chroma);
        logic signed [17:0] q;
        q = (s >>> 8) + (chroma ? 18'sd128 : 18'sd0);
        if (q < 18'sd0)
            level = 9'h180;
        else if (q > 18'sd255)
            level = 9'h07f;
        else
            level = q[8:0] - 9'd128;
    endfunction

    assign set_full = v2 && (i2 == 6'd63) && !clr;

    always_ff @(posedge clk) begin
        if (clr) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            in_bank <= 1'b0;
            in_cnt  <= 6'd0;
            full    <= 2'b00;
        end else begin
            v1 <= accept;
            if (accept) begin
                b1     <= in_bank;
                i1     <= in_cnt;
                sy1    <= sum_y;
                scb1   <= sum_cb;
                scr1   <= sum_cr;
                in_cnt <= in_cnt + 6'd1;
                if (in_cnt == 6'd63)
                    in_bank <= ~in_bank;
            end
            v2   <= v1;
            b2   <= b1;
            i2   <= i1;
            y2   <= level(sy1, 1'b0);
            cb2  <= level(scb1, 1'b1);
            cr2  <= level(scr1, 1'b1);
            full <= full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (v2 && !clr) begin
            mem_y[{b2, i2}] <= y2;
            if (!gray) begin
                mem_cb[{b2, i2}] <= cb2;
                mem_cr[{b2, i2}] <= cr2;
            end
        end
    end

    always_comb begin
        full_nxt = full;
        if (set_full)
            full_nxt[b2] = 1'b1;
        if (free)
            full_nxt[rd_bank] = 1'b0;
    end

    assign rd_addr    = {rd_bank, rd_idx};
    assign rd_last    = (rd_idx == 6'd63) && (gray ? (rd_color == 2'd0) : (rd_color == 2'd2));
    // Includes a fill landing this cycle so a back-to-back block skips IDLE.
    assign other_full = full[~rd_bank] || (set_full && (b2 != rd_bank));

    always_ff @(posedge clk) begin
        if (clr)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        done      = 1'b0;
        free      = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank])
                    state_nxt = READ;
            end
            READ: begin
                load      = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                if (OutReady) begin
                    done = 1'b1;
                    if (rd_last) begin
                        free      = 1'b1;
                        state_nxt = other_full ? READ : IDLE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            OutEnable <= 1'b0;
            OutColor  <= 2'd0;
            OutIndex  <= 6'd0;
            OutData   <= 9'd0;
            OutLast   <= 1'b0;
            rd_bank   <= 1'b0;
            rd_color  <= 2'd0;
            rd_idx    <= 6'd0;
        end else begin
            if (load) begin
                OutEnable <= 1'b1;
                OutColor  <= rd_color;
                OutIndex  <= rd_idx;
                OutLast   <= rd_last;
                case (rd_color)
                    2'd0:    OutData <= mem_y[rd_addr];
                    2'd1:    OutData <= mem_cb[rd_addr];
                    default: OutData <= mem_cr[rd_addr];
                endcase
            end
            if (done) begin
                OutEnable <= 1'b0;
                if (rd_last) begin
                    rd_color <= 2'd0;
                    rd_idx   <= 6'd0;
                    rd_bank  <= ~rd_bank;
                end else if (rd_idx == 6'd63) begin
                    rd_color <= rd_color + 2'd1;
                    rd_idx   <= 6'd0;
                end else begin
                    rd_idx <= rd_idx + 6'd1;
                end
            end
        end
    end

endmodule
